// File: rtl/mem_lsu_if.sv
// mem_lsu_if: request/response handshake and byte-wide datamem bus of mem_lsu.
// slave modport is the LSU side; master modport is the requester/memory side.
interface mem_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_address;
   logic [7:0]  mem_data_in;
   logic        mem_write_en;
   logic [7:0]  mem_data_out;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_data_in, mem_write_en
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_data_in, mem_write_en
   );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: byte-serial load/store unit in front of a byte-wide datamem.
// Accepts one request in IDLE, moves one byte per ACCESS cycle (little-endian),
// then pulses a response in RESP. Out-of-range or illegal-size requests skip
// memory entirely. Define LSU_MISALIGN_CHECK_EN to also reject misaligned
// halfword/word requests; otherwise they run byte-by-byte like any other.
module mem_lsu #(
   parameter int unsigned MEM_DEPTH = 4096
) (
   input logic      clk,
   input logic      reset,
   mem_lsu_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic        err_q, err_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] buf_q, buf_d;
   logic [1:0]  k_q, k_d;

   logic [2:0]  nbytes;
   logic [32:0] last_addr;
   logic        misalign;
   logic        req_err;
   logic        accept;
   logic [1:0]  last_k;
   logic [31:0] ext_data;

   assign bus.req_ready = (state_q == IDLE) && !reset;
   assign accept        = bus.req_valid && bus.req_ready;

   // Decode the incoming request: byte count and rejection conditions.
   always_comb begin
      case (bus.req_size)
         2'b00:   nbytes = 3'd1;
         2'b01:   nbytes = 3'd2;
         default: nbytes = 3'd4;
      endcase
      // 33-bit sum so an address near 2^32 cannot wrap back into range
      last_addr = {1'b0, bus.req_addr} + 33'(nbytes) - 33'd1;
`ifdef LSU_MISALIGN_CHECK_EN
      misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
      req_err = (bus.req_size == 2'b11) || (last_addr > 33'(MEM_DEPTH - 1)) || misalign;
   end

   // Index of the final byte and sign/zero extension of the gathered load data.
   always_comb begin
      case (size_q)
         2'b00:   last_k = 2'd0;
         2'b01:   last_k = 2'd1;
         default: last_k = 2'd3;
      endcase
      case (size_q)
         2'b00:   ext_data = uns_q ? {24'h0, buf_q[7:0]}  : {{24{buf_q[7]}}, buf_q[7:0]};
         2'b01:   ext_data = uns_q ? {16'h0, buf_q[15:0]} : {{16{buf_q[15]}}, buf_q[15:0]};
         default: ext_data = buf_q;
      endcase
   end

   // FSM next-state, request latching, byte sequencing and bus outputs.
   always_comb begin
      state_d          = state_q;
      we_d             = we_q;
      size_d           = size_q;
      uns_d            = uns_q;
      err_d            = err_q;
      addr_d           = addr_q;
      wdata_d          = wdata_q;
      buf_d            = buf_q;
      k_d              = k_q;
      bus.rsp_valid    = 1'b0;
      bus.rsp_rdata    = '0;
      bus.rsp_err      = 1'b0;
      bus.mem_address  = '0;
      bus.mem_data_in  = '0;
      bus.mem_write_en = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               we_d    = bus.req_we;
               size_d  = bus.req_size;
               uns_d   = bus.req_unsigned;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               err_d   = req_err;
               buf_d   = '0;
               k_d     = '0;
               state_d = req_err ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            bus.mem_address = addr_q + 32'(k_q);
            if (we_q) begin
               bus.mem_write_en = 1'b1;
               case (k_q)
                  2'd0:    bus.mem_data_in = wdata_q[7:0];
                  2'd1:    bus.mem_data_in = wdata_q[15:8];
                  2'd2:    bus.mem_data_in = wdata_q[23:16];
                  default: bus.mem_data_in = wdata_q[31:24];
               endcase
            end else begin
               buf_d[{k_q, 3'b000} +: 8] = bus.mem_data_out;
            end
            if (k_q == last_k) begin
               k_d     = '0;
               state_d = RESP;
            end else begin
               k_d = k_q + 2'd1;
            end
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            bus.rsp_err   = err_q;
            bus.rsp_rdata = (err_q || we_q) ? '0 : ext_data;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         buf_q   <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         buf_q   <= buf_d;
         k_q     <= k_d;
      end
   end

endmodule
